// File: rtl/pipe_pkg.sv
// Shared widths and per-boundary bundle layouts for the RV32I pipeline stages.
// Every stage instance takes its CTRL_W/DATA_W defaults from the structs below.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] funct3;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
  } data_t;

  localparam int EXMEM_CTRL_W = $bits(ctrl_t);
  localparam int EXMEM_DATA_W = $bits(data_t);

  // Encoded as {M.valid, S.valid}; the slot valid flops are the state register.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_t;

  function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
    return {1'b0, m_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control and data. Clear wins over load and
// zeroes valid+ctrl only; data keeps its last value.
module pipe_slot #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 133
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline boundary register: main slot M drives the outputs, optional
// skid slot S absorbs one extra entry so in_ready can come straight from a flop.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Handshake: a side transfers in a cycle exactly when its valid and ready are
  // both high at the rising edge; valid never depends on ready of the same side.
  logic              in_fire, out_fire;
  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ld_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_ld_data;
  logic              m_load, m_clear;
  skid_state_t       skid_state;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = m_valid && out_ready;
  assign skid_state = skid_state_t'({m_valid, s_valid});

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (m_load),
    .clear   (m_clear),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  if (SKID) begin : g_skid
    logic s_load, s_clear;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (s_load),
      .clear   (s_clear),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (s_valid),
      .ctrl    (s_ctrl),
      .data    (s_data)
    );

    assign in_ready = !s_valid;

    always_comb begin
      m_load    = 1'b0;
      m_clear   = 1'b0;
      m_ld_ctrl = in_ctrl;
      m_ld_data = in_data;
      s_load    = 1'b0;
      s_clear   = 1'b0;
      if (flush) begin
        m_clear = 1'b1;
        s_clear = 1'b1;
      end else begin
        case (skid_state)
          SKID_EMPTY: m_load = in_fire;
          SKID_ONE: begin
            if (in_fire && !out_fire)      s_load  = 1'b1;
            else if (in_fire)              m_load  = 1'b1;
            else if (out_fire)             m_clear = 1'b1;
          end
          SKID_FULL: begin
            if (out_fire) begin
              m_load    = 1'b1;
              m_ld_ctrl = s_ctrl;
              m_ld_data = s_data;
              s_clear   = 1'b1;
            end
          end
          default: begin
            m_clear = 1'b1;
            s_clear = 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    assign s_valid  = 1'b0;
    assign s_ctrl   = '0;
    assign s_data   = '0;
    assign in_ready = out_ready || !m_valid;

    always_comb begin
      m_ld_ctrl = in_ctrl;
      m_ld_data = in_data;
      m_load    = !flush && in_fire;
      m_clear   = flush || (out_fire && !in_fire);
    end
  end

  // Empty slots always present zero control so no write strobe leaks out.
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: one SKID=0 and one SKID=1 instance,
// each checked every cycle against a queue model plus literal expectations.
module tb_pipe_stage_elastic;

  localparam int CW = 7;
  localparam int DW = 133;
  localparam int EW = CW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Index 0: SKID=0 instance, index 1: SKID=1 instance.
  logic          in_valid_v [2];
  logic          in_ready_v [2];
  logic [CW-1:0] in_ctrl_v  [2];
  logic [DW-1:0] in_data_v  [2];
  logic          flush_v    [2];
  logic          out_valid_v[2];
  logic          out_ready_v[2];
  logic [CW-1:0] out_ctrl_v [2];
  logic [DW-1:0] out_data_v [2];
  logic [1:0]    occ_v      [2];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] dat_a, dat_b, dat_c, dat_d;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[0]),
    .in_ready  (in_ready_v[0]),
    .in_ctrl   (in_ctrl_v[0]),
    .in_data   (in_data_v[0]),
    .flush     (flush_v[0]),
    .out_valid (out_valid_v[0]),
    .out_ready (out_ready_v[0]),
    .out_ctrl  (out_ctrl_v[0]),
    .out_data  (out_data_v[0]),
    .occupancy (occ_v[0])
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[1]),
    .in_ready  (in_ready_v[1]),
    .in_ctrl   (in_ctrl_v[1]),
    .in_data   (in_data_v[1]),
    .flush     (flush_v[1]),
    .out_valid (out_valid_v[1]),
    .out_ready (out_ready_v[1]),
    .out_ctrl  (out_ctrl_v[1]),
    .out_data  (out_data_v[1]),
    .occupancy (occ_v[1])
  );

  task automatic check(input string name, input int d, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, d, act, exp, $time);
  endtask

  // ---------------- model: FIFO of accepted entries, capacity 1 or 2 --------
  function automatic int q_size(input int d);
    return (d == 1) ? exp_q1.size() : exp_q0.size();
  endfunction

  function automatic logic [EW-1:0] q_front(input int d);
    if (d == 1) return exp_q1[0];
    return exp_q0[0];
  endfunction

  function automatic bit m_in_ready(input int d);
    if (d == 1) return q_size(1) < 2;
    return out_ready_v[d] || (q_size(0) == 0);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int            sz;
      bit            inf, outf;
      logic [EW-1:0] e;
      sz   = q_size(d);
      inf  = in_valid_v[d] && m_in_ready(d);
      outf = (sz > 0) && out_ready_v[d];
      e    = {in_ctrl_v[d], in_data_v[d]};
      if (!rst_n || flush_v[d]) begin
        if (d == 1) exp_q1.delete(); else exp_q0.delete();
      end else begin
        if (outf) begin
          if (d == 1) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
        end
        if (inf) begin
          if (d == 1) exp_q1.push_back(e); else exp_q0.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin : compare
    int            sz;
    logic [EW-1:0] f;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        sz = q_size(d);
        f  = (sz > 0) ? q_front(d) : '0;
        check("out_valid", d, EW'(out_valid_v[d]), EW'(sz > 0));
        check("out_ctrl",  d, EW'(out_ctrl_v[d]),  EW'(f[EW-1:DW]));
        if (sz > 0) check("out_data", d, EW'(out_data_v[d]), EW'(f[DW-1:0]));
        check("occupancy", d, EW'(occ_v[d]),       EW'(sz));
        check("in_ready",  d, EW'(in_ready_v[d]),  EW'(m_in_ready(d)));
      end
    end
  end

  // ---------------- drivers ------------------------------------------------
  task automatic drive(input int d, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] x, input logic ordy, input logic fl);
    in_valid_v[d]  = v;
    in_ctrl_v[d]   = c;
    in_data_v[d]   = x;
    out_ready_v[d] = ordy;
    flush_v[d]     = fl;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic lit_out(input int d, input logic v, input logic [CW-1:0] c,
                         input logic [1:0] occ);
    check("lit_out_valid", d, EW'(out_valid_v[d]), EW'(v));
    check("lit_out_ctrl",  d, EW'(out_ctrl_v[d]),  EW'(c));
    check("lit_occupancy", d, EW'(occ_v[d]),       EW'(occ));
  endtask

  initial begin
    dat_a = {5'h0A, {4{32'hAAAA_0001}}};
    dat_b = {5'h0B, {4{32'hBBBB_0002}}};
    dat_c = {5'h0C, {4{32'hCCCC_0003}}};
    dat_d = {5'h0D, {4{32'hDDDD_0004}}};
    idle(0);
    idle(1);

    // Reset values.
    #12;
    for (int d = 0; d < 2; d++) begin
      lit_out(d, 1'b0, 7'h00, 2'd0);
      check("lit_reset_data", d, EW'(out_data_v[d]), '0);
      check("lit_reset_in_ready", d, EW'(in_ready_v[d]), EW'(1'b1));
    end
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming with out_ready held high, both modes.
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 7'h5B, dat_a, 1'b1, 1'b0);
    tick();
    for (int d = 0; d < 2; d++) begin
      lit_out(d, 1'b1, 7'h5B, 2'd1);
      check("lit_data_a", d, EW'(out_data_v[d]), EW'(dat_a));
      drive(d, 1'b1, 7'h11, dat_b, 1'b1, 1'b0);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      lit_out(d, 1'b1, 7'h11, 2'd1);
      check("lit_data_b", d, EW'(out_data_v[d]), EW'(dat_b));
      drive(d, 1'b1, 7'h22, dat_c, 1'b1, 1'b0);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      lit_out(d, 1'b1, 7'h22, 2'd1);
      check("lit_data_c", d, EW'(out_data_v[d]), EW'(dat_c));
      idle(d);
    end

    // Bubble: three empty cycles must present zero control.
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 2; d++) lit_out(d, 1'b0, 7'h00, 2'd0);
    end

    // SKID=1 backpressure into FULL, then drain A then B.
    drive(1, 1'b1, 7'h5B, dat_a, 1'b1, 1'b0);
    tick();
    lit_out(1, 1'b1, 7'h5B, 2'd1);
    drive(1, 1'b1, 7'h11, dat_b, 1'b0, 1'b0);
    tick();
    lit_out(1, 1'b1, 7'h5B, 2'd2);
    check("lit_full_in_ready", 1, EW'(in_ready_v[1]), EW'(1'b0));
    check("lit_full_data_a", 1, EW'(out_data_v[1]), EW'(dat_a));
    drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    lit_out(1, 1'b1, 7'h11, 2'd1);
    check("lit_drain_data_b", 1, EW'(out_data_v[1]), EW'(dat_b));
    check("lit_recover_in_ready", 1, EW'(in_ready_v[1]), EW'(1'b1));
    tick();
    lit_out(1, 1'b0, 7'h00, 2'd0);

    // Flush while FULL with D offered on the input.
    drive(1, 1'b1, 7'h5B, dat_a, 1'b1, 1'b0);
    tick();
    drive(1, 1'b1, 7'h11, dat_b, 1'b0, 1'b0);
    tick();
    lit_out(1, 1'b1, 7'h5B, 2'd2);
    drive(1, 1'b1, 7'h33, dat_d, 1'b0, 1'b1);
    tick();
    lit_out(1, 1'b0, 7'h00, 2'd0);
    check("lit_flush_in_ready", 1, EW'(in_ready_v[1]), EW'(1'b1));
    idle(1);
    for (int i = 0; i < 2; i++) begin
      tick();
      lit_out(1, 1'b0, 7'h00, 2'd0);
    end

    // Flush discards a simultaneous in_fire, both modes.
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 7'h5B, dat_a, 1'b1, 1'b0);
    tick();
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 7'h33, dat_d, 1'b1, 1'b1);
    tick();
    for (int d = 0; d < 2; d++) begin
      lit_out(d, 1'b0, 7'h00, 2'd0);
      idle(d);
    end
    tick();
    for (int d = 0; d < 2; d++) lit_out(d, 1'b0, 7'h00, 2'd0);

    // Asynchronous reset mid-cycle while FULL; nothing replays after release.
    drive(1, 1'b1, 7'h5B, dat_a, 1'b1, 1'b0);
    tick();
    drive(1, 1'b1, 7'h11, dat_b, 1'b0, 1'b0);
    tick();
    lit_out(1, 1'b1, 7'h5B, 2'd2);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    lit_out(1, 1'b0, 7'h00, 2'd0);
    idle(1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      lit_out(1, 1'b0, 7'h00, 2'd0);
    end

    // SKID=0 combinational ready pass-through and back-to-back transfers.
    drive(0, 1'b1, 7'h5B, dat_a, 1'b1, 1'b0);
    tick();
    lit_out(0, 1'b1, 7'h5B, 2'd1);
    drive(0, 1'b1, 7'h11, dat_b, 1'b0, 1'b0);
    #1;
    check("lit_s0_stall_ready", 0, EW'(in_ready_v[0]), EW'(1'b0));
    tick();
    lit_out(0, 1'b1, 7'h5B, 2'd1);
    check("lit_s0_hold_ready", 0, EW'(in_ready_v[0]), EW'(1'b0));
    drive(0, 1'b1, 7'h11, dat_b, 1'b1, 1'b0);
    #1;
    check("lit_s0_pass_ready", 0, EW'(in_ready_v[0]), EW'(1'b1));
    tick();
    lit_out(0, 1'b1, 7'h11, 2'd1);
    check("lit_s0_data_b", 0, EW'(out_data_v[0]), EW'(dat_b));
    drive(0, 1'b1, 7'h22, dat_c, 1'b1, 1'b0);
    tick();
    lit_out(0, 1'b1, 7'h22, 2'd1);
    check("lit_s0_data_c", 0, EW'(out_data_v[0]), EW'(dat_c));
    idle(0);
    tick();
    lit_out(0, 1'b0, 7'h00, 2'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
